// File: rtl/fip_32_to_fp32.sv
// Signed Q(32-FRA_BITS).FRA_BITS fixed-point to IEEE-754 single, 3-stage pipe with global stall.
// Define FIP_FP32_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fip_32_to_fp32 #(
  parameter int FRA_BITS = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic [31:0] i_x,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_f
);

`ifdef FIP_FP32_RNE_EN
  localparam int NLO = 0;
`else
  localparam int NLO = 8;
`endif

  function automatic logic [5:0] clz32(input logic [31:0] v);
    clz32 = 6'd32;
    for (int i = 0; i < 32; i++)
      if (v[i]) clz32 = 6'(31 - i);
  endfunction

  // nrm holds the normalized value below its hidden bit.
  function automatic logic [31:0] round_pack(input logic sgn, input logic [7:0] ex,
                                             input logic [30:NLO] nrm);
`ifdef FIP_FP32_RNE_EN
    logic [23:0] sum;
    sum = {1'b0, nrm[30:8]} + 24'(nrm[7] & (nrm[8] | (|nrm[6:0])));
    return {sgn, ex + 8'(sum[23]), sum[22:0]};
`else
    return {sgn, ex, nrm[30:8]};
`endif
  endfunction

  logic              adv;
  logic signed [31:0] x_s;
  logic              vld_p0, vld_p1;
  logic              s_p0, s_p1, z_p1;
  logic [31:0]       m_p0;
  logic [5:0]        lz;
  logic [7:0]        e_p1;
  logic [30:NLO]     n_p1;

  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;
  assign x_s     = i_x;
  assign lz      = clz32(m_p0);

  // Stage 0: sign and magnitude (2^31 fits as unsigned)
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= i_en;
  end

  always_ff @(posedge i_clk) begin
    if (adv) begin
      s_p0 <= x_s[31];
      m_p0 <= x_s[31] ? 32'(-x_s) : i_x;
    end
  end

  // Stage 1: normalize and form the biased exponent
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= vld_p0;
  end

  always_ff @(posedge i_clk) begin
    if (adv) begin
      s_p1 <= s_p0;
      z_p1 <= (m_p0 == 32'd0);
      e_p1 <= 8'(158 - int'(lz) - FRA_BITS);
      n_p1 <= (31 - NLO)'((m_p0 << lz) >> NLO);
    end
  end

  // Stage 2: round and pack; zero always encodes as +0
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_f     <= 32'h0;
    end else if (adv) begin
      o_valid <= vld_p1;
      o_f     <= z_p1 ? 32'h0 : round_pack(s_p1, e_p1, n_p1);
    end
  end

endmodule

// File: tb/tb_fip_32_to_fp32.sv
// Bench for fip_32_to_fp32: directed values, stall, reset mid-flight and a random scoreboard run.
module tb_fip_32_to_fp32;
  localparam int FRA_BITS = 16;

  logic        i_clk = 1'b0;
  logic        i_rstn, i_en, i_ready;
  logic [31:0] i_x, o_f;
  logic        o_ready, o_valid;

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;
  logic [31:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  fip_32_to_fp32 #(.FRA_BITS(FRA_BITS)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_x(i_x),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready), .o_f(o_f)
  );

  // Reference: exact integer magnitude, msb search, explicit remainder rounding.
  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    logic        sgn;
    logic [63:0] mag, mant;
    int          p, ex;
`ifdef FIP_FP32_RNE_EN
    logic [63:0] rem, half;
`endif
    sgn = x[31];
    mag = sgn ? (64'd4294967296 - {32'd0, x}) : {32'd0, x};
    if (mag == 64'd0) return 32'h0;
    p = 0;
    while ((mag >> p) > 64'd1) p++;
    ex = p - FRA_BITS + 127;
    if (p > 23) begin
      mant = mag >> (p - 23);
`ifdef FIP_FP32_RNE_EN
      rem  = mag & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        ex++;
      end
`endif
    end else begin
      mant = mag << (23 - p);
    end
    return {sgn, 8'(ex), mant[22:0]};
  endfunction

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      exp_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h expected=none", o_f);
        end else begin
          e = exp_q.pop_front();
          if (o_f !== e) begin
            bad++;
            $display("FAIL sb_data idx=%0d got=%h expected=%h", n_out, o_f, e);
          end
        end
        n_out++;
      end
      if (i_en && o_ready) begin
        exp_q.push_back(ref_fp(i_x));
        n_in++;
      end
    end
  end

  task automatic test_reset();
    i_rstn = 1'b0; i_en = 1'b0; i_x = 32'h0; i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b expected=0", o_valid); end
    total++; if (o_f !== 32'h0) begin bad++; $display("FAIL rst_f got=%h expected=00000000", o_f); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b expected=1", o_ready); end
    @(posedge i_clk); #1 i_rstn = 1'b1;
  endtask

  task automatic send_one(input string name, input logic [31:0] x, input logic [31:0] expv);
    int lat = 0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_en = 1'b1; i_x = x;
    do begin
      @(posedge i_clk); lat++;
      #1 i_en = 1'b0;
      @(negedge i_clk);
    end while (!o_valid && lat < 10);
    total++;
    if (lat != 3) begin bad++; $display("FAIL %s_latency got=%0d expected=3", name, lat); end
    total++;
    if (o_f !== expv) begin bad++; $display("FAIL %s_value got=%h expected=%h", name, o_f, expv); end
  endtask

  task automatic test_basic();
    send_one("one",     32'h0001_0000, 32'h3F80_0000);
    send_one("neg_one", 32'hFFFF_0000, 32'hBF80_0000);
    send_one("half",    32'h0000_8000, 32'h3F00_0000);
    send_one("zero",    32'h0000_0000, 32'h0000_0000);
  endtask

  task automatic test_extremes();
    send_one("min_neg", 32'h8000_0000, 32'hC700_0000);
`ifdef FIP_FP32_RNE_EN
    send_one("max_pos", 32'h7FFF_FFFF, 32'h4700_0000);
`else
    send_one("max_pos", 32'h7FFF_FFFF, 32'h46FF_FFFF);
`endif
  endtask

  task automatic test_ties();
    send_one("tie_even", 32'h0100_0001, 32'h4380_0000);
`ifdef FIP_FP32_RNE_EN
    send_one("tie_odd",  32'h0100_0003, 32'h4380_0002);
`else
    send_one("tie_odd",  32'h0100_0003, 32'h4380_0001);
`endif
  endtask

  task automatic drain(input string name);
    int w = 0;
    i_en = 1'b0; i_ready = 1'b1;
    while (exp_q.size() != 0 && w < 50) begin @(negedge i_clk); w++; end
    repeat (2) @(negedge i_clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL %s_drain left=%0d expected=0", name, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals[8];
    int start;
    foreach (vals[k]) vals[k] = $urandom;
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    start = n_out;
    fork
      begin
        int i = 0;
        logic rdy;
        while (i < 8) begin
          i_en = 1'b1; i_x = vals[i];
          @(negedge i_clk); rdy = o_ready;
          @(posedge i_clk); #1;
          if (rdy) i++;
        end
        i_en = 1'b0;
      end
      begin
        logic [31:0] f0;
        repeat (4) @(posedge i_clk);
        #1 i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge i_clk);
          if (k == 0) f0 = o_f;
          total++;
          if (o_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b expected=1", k, o_valid); end
          total++;
          if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b expected=0", k, o_ready); end
          if (k > 0) begin
            total++;
            if (o_f !== f0) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h expected=%h", k, o_f, f0); end
          end
        end
        @(posedge i_clk); #1 i_ready = 1'b1;
      end
    join
    drain("bp");
    total++;
    if (n_out - start != 8) begin bad++; $display("FAIL bp_count got=%0d expected=8", n_out - start); end
  endtask

  task automatic test_reset_midflight();
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_en = 1'b1; i_x = $urandom;
      @(posedge i_clk); #1;
    end
    i_en = 1'b0;
    i_rstn = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b expected=0", o_valid); end
    total++; if (o_f !== 32'h0) begin bad++; $display("FAIL mid_rst_f got=%h expected=00000000", o_f); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b expected=1", o_ready); end
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b expected=0", k, o_valid); end
    end
    send_one("post_rst", 32'h0003_0000, 32'h4040_0000);
  endtask

  task automatic test_random();
    int start = n_in;
    int cyc = 0;
    logic [31:0] t;
    while (n_in - start < 10000 && cyc < 60000) begin
      @(posedge i_clk); #1;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t = t >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 0) t = -t;
      i_x = t;
      i_en = ($urandom_range(0, 9) < 8);
      i_ready = ($urandom_range(0, 9) < 7);
      cyc++;
    end
    @(posedge i_clk); #1;
    total++;
    if (n_in - start < 10000) begin bad++; $display("FAIL rnd_timeout got=%0d expected=10000", n_in - start); end
    drain("rnd");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_ties();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
